word_counter: RTL and testbench
===============================

Name: word_counter

Overview:
- Per-output-port word counter that sits directly downstream of the four output FIFOs (ports 4..7) of the switch fabric.
- Counts every word actually delivered by a POP on each output FIFO.
- Exposes the counts through a request/index read port that is honoured only while the main control FSM reports IDLE.
- Read by the test harness to confirm end-to-end word delivery.

Parameters:
- NUM_PORTS, 4, number of output FIFOs monitored.
- IDX_W, 2, width of the read index; must satisfy 2**IDX_W >= NUM_PORTS.
- CNT_W, 5, width of each per-port counter and of the read data.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- init  input  1  main FSM in INIT state; clears all counters.
- IDLE  input  1  main FSM in IDLE state; read port enabled.
- pop  input  NUM_PORTS  pop strobe per output FIFO; bit 0 = FIFO 4.
- fifo_empty  input  NUM_PORTS  empty flag per output FIFO, same bit order.
- req  input  1  read request.
- idx  input  IDX_W  counter index to read.
- valid_contador  output  1  read data valid.
- contador_out  output  CNT_W  counter value for the requested index.

Behaviour:
- Reset (asynchronous, active-high): all counters = 0, valid_contador = 0, contador_out = 0, FSM = CLEAR.
- Count qualification: counter[i] increments by 1 on a rising edge when pop[i] = 1 and fifo_empty[i] = 0. A pop on an empty FIFO is ignored.
- Multiple ports may increment in the same cycle, independently.
- Wrap-around: counters are CNT_W bits unsigned. Default behaviour is modulo wrap: 31 + 1 -> 0 for CNT_W = 5.
- FSM, three states:
  - CLEAR: counters held at 0, reads ignored. Entered from reset or whenever init = 1. Goes to COUNT on the first cycle with init = 0.
  - COUNT: counting active, read port disabled. Goes to READ when IDLE = 1 and init = 0.
  - READ: counting stays active and the read port is enabled. Goes back to COUNT when IDLE = 0. Goes to CLEAR when init = 1.
- init has priority over IDLE. An init = 1 pulse in any state clears all counters on that edge.
- Read port:
  - In READ with req = 1, the design samples idx at edge N.
  - At edge N+1: contador_out = counter[idx] as it was before edge N's increment, and valid_contador = 1.
  - Latency is 1 cycle, fully pipelined: with req held high and idx changing every cycle, one result comes out per cycle, in order.
  - If req = 0, or the FSM is not in READ: valid_contador = 0 on the next edge and contador_out holds its last value.
  - idx >= NUM_PORTS returns 0 with valid_contador = 1.
- Simultaneous pop and read of the same index: the read returns the pre-increment value and the increment is not lost.
- Reading never clears or modifies any counter.
- If reset is asserted mid-read, outputs return to reset values immediately. No response is issued for the in-flight request.

Optional Feature:
- Macro: WORD_COUNTER_SATURATE_EN.
- Defined: counters saturate at 2**CNT_W - 1. Further qualified pops leave the counter at that maximum, and a per-port sticky overflow bit is set. The overflow bits are cleared only by reset or init. When the sticky bit of the selected index is set, contador_out returns the saturated value; valid_contador is unaffected.
- Undefined: counters wrap modulo 2**CNT_W, and no overflow bits or logic exist.

Decomposition:
- Shared package: FSM state encoding (CLEAR/COUNT/READ as a 2-bit enum) and the default constants NUM_PORTS = 4, CNT_W = 5, IDX_W = 2, so the arbiter, the FIFOs and the benches use identical values.
- One natural sub-module: port_counter, a single CNT_W counter with clear, increment-qualify and the optional saturation logic. It is instantiated NUM_PORTS times inside word_counter.
- The FSM and the read mux/pipeline register stay in the top block.

Test Plan:
- Reset/init: reset = 1 then 0, init = 1 for 3 cycles then 0 -> all counters 0; IDLE = 1, req = 1, idx = 0..3 -> contador_out = 0,0,0,0 with valid_contador = 1 on each cycle after the request.
- Qualified pops: 4 pops per port with fifo_empty = 0, plus 2 pops on port 2 with fifo_empty = 1 -> reads return 4,4,4,4.
- Pipelined read under traffic: counters at 3, req held, idx = 0 with a simultaneous pop on port 0 -> first read = 3, re-read idx 0 next cycle -> 4. With IDLE = 0, req = 1 -> valid_contador stays 0.
- Wrap: 33 qualified pops on port 1 -> read = 1 without the macro; with WORD_COUNTER_SATURATE_EN -> read = 31 and the overflow bit for port 1 is set.
- Clear and priority: counters at 4, assert init = 1 and IDLE = 1 together -> FSM goes to CLEAR, next reads return 0. Assert reset mid-read -> valid_contador = 0 immediately.

Source files
------------

// File: rtl/word_counter_pkg.sv
// Shared definitions for the output-port word counter.
// Holds the main FSM state encoding and the default sizing constants so the
// fabric, the FIFOs and the benches agree on the same values.
// Optional feature macro: WORD_COUNTER_SATURATE_EN (saturating counters with
// sticky per-port overflow bits instead of modulo wrap).
package word_counter_pkg;

    // Default sizing: four monitored output FIFOs (fabric ports 4..7)
    localparam int DEF_NUM_PORTS = 4;
    localparam int DEF_IDX_W     = 2;
    localparam int DEF_CNT_W     = 5;

    // CLEAR holds counters at zero, COUNT counts only, READ counts and serves reads
    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_COUNT = 2'd1,
        ST_READ  = 2'd2
    } wc_state_e;

endpackage : word_counter_pkg

// File: rtl/word_counter_port_counter.sv
// Single per-port word counter with synchronous clear and a qualified
// increment. Wraps modulo 2**CNT_W by default; with WORD_COUNTER_SATURATE_EN
// defined it stops at the maximum value and raises a sticky overflow bit that
// only reset or clear can drop.
module port_counter
    import word_counter_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
`ifdef WORD_COUNTER_SATURATE_EN
    ,
    output logic             ovf
`endif
);

`ifdef WORD_COUNTER_SATURATE_EN
    // Saturating count with sticky overflow flag
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
            ovf <= 1'b0;
        end else if (clear) begin
            cnt <= '0;
            ovf <= 1'b0;
        end else if (inc) begin
            if (cnt == {CNT_W{1'b1}}) begin
                ovf <= 1'b1;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end
`else
    // Modulo count: max + 1 wraps to zero
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= cnt + 1'b1;
        end
    end
`endif

endmodule : port_counter

// File: rtl/word_counter.sv
// Per-output-port word counter for the switch fabric output FIFOs.
// Counts every word actually delivered by a pop (pop while not empty) and
// exposes the counts through a request/index read port that is only served
// while the main control FSM reports IDLE.
// Optional feature macro: WORD_COUNTER_SATURATE_EN.
//
// Read handshake: the read port has no back-pressure. When the local FSM is in
// READ and req = 1 at a rising edge, idx is sampled at that edge and the
// counter value it held just before that edge is registered onto
// contador_out with valid_contador = 1, visible for the following cycle.
// Any edge without an accepted request drops valid_contador and leaves
// contador_out unchanged. One request per cycle is accepted, results in order.
module word_counter
    import word_counter_pkg::*;
#(
    parameter int NUM_PORTS = DEF_NUM_PORTS,
    parameter int IDX_W     = DEF_IDX_W,
    parameter int CNT_W     = DEF_CNT_W
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 init,
    input  logic                 IDLE,
    input  logic [NUM_PORTS-1:0] pop,
    input  logic [NUM_PORTS-1:0] fifo_empty,
    input  logic                 req,
    input  logic [IDX_W-1:0]     idx,
    output logic                 valid_contador,
    output logic [CNT_W-1:0]     contador_out
);

    wc_state_e      state;
    logic           clear_cnt;
    logic           count_en;
    logic           rd_accept;
    logic [CNT_W-1:0] rd_data;
    logic [CNT_W-1:0] cnt [NUM_PORTS];
`ifdef WORD_COUNTER_SATURATE_EN
    logic [NUM_PORTS-1:0] ovf;
`endif

    // Counter control: init clears on the same edge regardless of state
    always_comb begin
        clear_cnt = init || (state == ST_CLEAR);
        count_en  = (state != ST_CLEAR);
        rd_accept = (state == ST_READ) && req;
    end

    for (genvar g = 0; g < NUM_PORTS; g++) begin : g_port
        port_counter #(
            .CNT_W (CNT_W)
        ) u_port_counter (
            .clk   (clk),
            .reset (reset),
            .clear (clear_cnt),
            .inc   (count_en && pop[g] && !fifo_empty[g]),
            .cnt   (cnt[g])
`ifdef WORD_COUNTER_SATURATE_EN
            ,
            .ovf   (ovf[g])
`endif
        );
    end

    // Read mux: out-of-range index yields zero; saturated ports return the max
    always_comb begin
        rd_data = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (idx == IDX_W'(i)) begin
`ifdef WORD_COUNTER_SATURATE_EN
                rd_data = ovf[i] ? {CNT_W{1'b1}} : cnt[i];
`else
                rd_data = cnt[i];
`endif
            end
        end
    end

    // Main FSM plus registered read response
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= ST_CLEAR;
            valid_contador <= 1'b0;
            contador_out   <= '0;
        end else begin
            case (state)
                ST_CLEAR: begin
                    if (!init) state <= ST_COUNT;
                end
                ST_COUNT: begin
                    if (init)      state <= ST_CLEAR;
                    else if (IDLE) state <= ST_READ;
                end
                ST_READ: begin
                    if (init)       state <= ST_CLEAR;
                    else if (!IDLE) state <= ST_COUNT;
                end
                default: state <= ST_CLEAR;
            endcase

            valid_contador <= rd_accept;
            if (rd_accept) begin
                contador_out <= rd_data;
            end
        end
    end

endmodule : word_counter

// File: tb/tb_word_counter.sv
// Directed bench for word_counter: reset/init, qualified pops, pipelined
// reads under traffic, wrap (or saturation), init priority and reset mid-read.
module tb_word_counter;
    import word_counter_pkg::*;

    logic       clk;
    logic       reset;
    logic       init;
    logic       IDLE;
    logic [3:0] pop;
    logic [3:0] fifo_empty;
    logic       req;
    logic [1:0] idx;
    logic       valid_contador;
    logic [4:0] contador_out;

    int tests_run;
    int tests_failed;

    word_counter dut (
        .clk            (clk),
        .reset          (reset),
        .init           (init),
        .IDLE           (IDLE),
        .pop            (pop),
        .fifo_empty     (fifo_empty),
        .req            (req),
        .idx            (idx),
        .valid_contador (valid_contador),
        .contador_out   (contador_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic read_chk(input string tag, input logic [1:0] i, input logic [4:0] exp);
        req = 1'b1;
        idx = i;
        cycle();
        chk({tag, "_valid"}, 32'(valid_contador), 32'd1);
        chk({tag, "_data"}, 32'(contador_out), 32'(exp));
    endtask

    task automatic pops(input logic [3:0] p, input logic [3:0] fe, input int n);
        pop = p;
        fifo_empty = fe;
        for (int k = 0; k < n; k++) cycle();
        pop = 4'h0;
        fifo_empty = 4'hf;
    endtask

    logic [4:0] wrap_exp;

    initial begin
        tests_run = 0;
        tests_failed = 0;
        reset = 1'b1;
        init = 1'b0;
        IDLE = 1'b0;
        pop = 4'h0;
        fifo_empty = 4'hf;
        req = 1'b0;
        idx = 2'd0;
        #1;
        chk("reset_valid", 32'(valid_contador), 32'd0);
        chk("reset_data", 32'(contador_out), 32'd0);
        chk("reset_state", 32'(dut.state), 32'(ST_CLEAR));
        cycle();
        cycle();
        reset = 1'b0;

        // init for three cycles, then into COUNT and READ
        init = 1'b1;
        cycle(); cycle(); cycle();
        init = 1'b0;
        cycle();
        chk("init_to_count", 32'(dut.state), 32'(ST_COUNT));
        IDLE = 1'b1;
        cycle();
        chk("count_to_read", 32'(dut.state), 32'(ST_READ));
        read_chk("init_rd0", 2'd0, 5'd0);
        read_chk("init_rd1", 2'd1, 5'd0);
        read_chk("init_rd2", 2'd2, 5'd0);
        read_chk("init_rd3", 2'd3, 5'd0);
        req = 1'b0;
        cycle();
        chk("noreq_valid", 32'(valid_contador), 32'd0);

        // Qualified pops: 4 per port, 2 ignored pops on empty port 2
        IDLE = 1'b0;
        pops(4'hf, 4'h0, 4);
        pops(4'b0100, 4'b0100, 2);
        IDLE = 1'b1;
        cycle();
        read_chk("pop_rd0", 2'd0, 5'd4);
        read_chk("pop_rd1", 2'd1, 5'd4);
        read_chk("pop_rd2", 2'd2, 5'd4);
        read_chk("pop_rd3", 2'd3, 5'd4);
        req = 1'b0;

        // Pipelined read under traffic, counters at 3
        init = 1'b1;
        IDLE = 1'b0;
        cycle();
        init = 1'b0;
        cycle();
        pops(4'hf, 4'h0, 3);
        IDLE = 1'b1;
        cycle();
        pop = 4'b0001;
        fifo_empty = 4'h0;
        read_chk("traffic_pre_inc", 2'd0, 5'd3);
        pop = 4'h0;
        fifo_empty = 4'hf;
        read_chk("traffic_post_inc", 2'd0, 5'd4);
        read_chk("traffic_rd1", 2'd1, 5'd3);
        IDLE = 1'b0;
        cycle();
        chk("leave_read_last_valid", 32'(valid_contador), 32'd1);
        cycle();
        chk("not_idle_valid", 32'(valid_contador), 32'd0);
        chk("not_idle_hold", 32'(contador_out), 32'd3);
        req = 1'b0;

        // Wrap / saturate: 33 pops on port 1
        init = 1'b1;
        cycle();
        init = 1'b0;
        cycle();
        pops(4'b0010, 4'h0, 33);
        IDLE = 1'b1;
        cycle();
`ifdef WORD_COUNTER_SATURATE_EN
        wrap_exp = 5'd31;
`else
        wrap_exp = 5'd1;
`endif
        read_chk("wrap_rd1", 2'd1, wrap_exp);
        read_chk("wrap_rd0", 2'd0, 5'd0);
`ifdef WORD_COUNTER_SATURATE_EN
        chk("sat_ovf", 32'(dut.ovf), 32'b0010);
`endif
        req = 1'b0;

        // init has priority over IDLE
        init = 1'b1;
        IDLE = 1'b0;
        cycle();
        init = 1'b0;
        cycle();
        pops(4'b1000, 4'h0, 4);
        IDLE = 1'b1;
        cycle();
        read_chk("prio_pre", 2'd3, 5'd4);
        req = 1'b0;
        init = 1'b1;
        cycle();
        chk("prio_state", 32'(dut.state), 32'(ST_CLEAR));
        chk("prio_valid", 32'(valid_contador), 32'd0);
        init = 1'b0;
        cycle();
        cycle();
        read_chk("prio_post", 2'd3, 5'd0);
        req = 1'b0;

        // Reset asserted in the middle of a read stream
        pops(4'b0100, 4'h0, 2);
        read_chk("pre_reset_rd2", 2'd2, 5'd2);
        reset = 1'b1;
        #1;
        chk("midrd_reset_valid", 32'(valid_contador), 32'd0);
        chk("midrd_reset_data", 32'(contador_out), 32'd0);
        chk("midrd_reset_state", 32'(dut.state), 32'(ST_CLEAR));
        cycle();
        chk("held_reset_valid", 32'(valid_contador), 32'd0);
        reset = 1'b0;
        req = 1'b0;
        cycle();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule : tb_word_counter
